// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard: register file with per-entry busy scoreboard, init FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [WIDTH-1:0]  wd_i,
  input  logic              rsv_valid_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              hazard_o,
  output logic              ready_o
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                w_run;
  logic                w_wa_zero;
  logic                w_rsv_zero;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_wa;
  logic [WIDTH-1:0]    w_mem_wd;

  assign w_run      = (state_q == S_RUN);
  assign w_wa_zero  = (ZERO_REG != 0) && (wa_i == '0);
  assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr_i == '0);
  assign ready_o    = w_run;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    busy_d     = busy_q;
    w_mem_we   = 1'b0;
    w_mem_wa   = wa_i;
    w_mem_wd   = wd_i;
    if (state_q == S_INIT) begin
      w_mem_we   = 1'b1;
      w_mem_wa   = init_cnt_q;
      w_mem_wd   = (INIT_MODE == 1) ? WIDTH'(init_cnt_q) : '0;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == c_LAST_IDX) begin
        state_d = S_RUN;
      end
    end else begin
      w_mem_we = we_i && !w_wa_zero;
      // Clear before set so a same-address reserve leaves the entry busy.
      if (we_i) begin
        busy_d[wa_i] = 1'b0;
      end
      if (rsv_valid_i && !w_rsv_zero) begin
        busy_d[rsv_addr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_mem_we) begin
      mem_q[w_mem_wa] <= w_mem_wd;
    end
  end

  logic [ADDR_W-1:0] w_rs_addr [2];
  logic [WIDTH-1:0]  w_rd      [2];
  logic              w_busy    [2];

  assign w_rs_addr[0] = rs1_addr_i;
  assign w_rs_addr[1] = rs2_addr_i;

  for (genvar g = 0; g < 2; g++) begin : g_rd_port
    logic w_zero_hit;
    logic w_bypass_hit;
    assign w_zero_hit   = (ZERO_REG != 0) && (w_rs_addr[g] == '0);
    assign w_bypass_hit = (BYPASS != 0) && we_i && (wa_i == w_rs_addr[g]);
    assign w_rd[g]      = (!w_run || w_zero_hit) ? '0
                        : w_bypass_hit ? wd_i : mem_q[w_rs_addr[g]];
    assign w_busy[g]    = w_run && !w_zero_hit && busy_q[w_rs_addr[g]] && !w_bypass_hit;
  end

  assign rd1_o    = w_rd[0];
  assign rd2_o    = w_rd[1];
  assign busy1_o  = w_busy[0];
  assign busy2_o  = w_busy[1];
  assign hazard_o = w_busy[0] || w_busy[1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard: directed bench for regfile_scoreboard (INIT_MODE=1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_addr_i, rs2_addr_i, wa_i, rsv_addr_i;
  logic [31:0] rd1_o, rd2_o, wd_i;
  logic        we_i, rsv_valid_i;
  logic        busy1_o, busy2_o, hazard_o, ready_o;

  int n_cmp = 0;
  int n_err = 0;

  regfile_scoreboard #(.INIT_MODE(1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rd1_o       (rd1_o),
    .rd2_o       (rd2_o),
    .we_i        (we_i),
    .wa_i        (wa_i),
    .wd_i        (wd_i),
    .rsv_valid_i (rsv_valid_i),
    .rsv_addr_i  (rsv_addr_i),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .hazard_o    (hazard_o),
    .ready_o     (ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ready must stay low for 31 edges after release and rise on the 32nd.
  task automatic check_init_window(input string tag);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk(tag, {31'd0, ready_o}, (k == 32) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    rs1_addr_i  = 5'd7;
    rs2_addr_i  = 5'd4;
    we_i        = 1'b0;
    wa_i        = 5'd0;
    wd_i        = 32'd0;
    rsv_valid_i = 1'b0;
    rsv_addr_i  = 5'd0;

    repeat (3) tick();
    chk("rst_ready",  {31'd0, ready_o},  32'd0);
    chk("rst_rd1",    rd1_o,             32'd0);
    chk("rst_rd2",    rd2_o,             32'd0);
    chk("rst_busy1",  {31'd0, busy1_o},  32'd0);
    chk("rst_hazard", {31'd0, hazard_o}, 32'd0);

    // Traffic during INIT must be ignored.
    rst_ni      = 1'b1;
    we_i        = 1'b1;
    wa_i        = 5'd2;
    wd_i        = 32'hFFFF_FFFF;
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 5'd4;
    #1;
    chk("init_rd1_zero", rd1_o, 32'd0);
    check_init_window("init_ready");
    we_i        = 1'b0;
    rsv_valid_i = 1'b0;
    rs1_addr_i  = 5'd7;
    rs2_addr_i  = 5'd7;
    #1;
    chk("run_rd1_r7",    rd1_o, 32'd7);
    chk("run_rd2_r7",    rd2_o, 32'd7);
    rs1_addr_i = 5'd2;
    rs2_addr_i = 5'd4;
    #1;
    chk("init_we_ignored",  rd1_o,             32'd2);
    chk("init_rsv_ignored", {31'd0, busy2_o},  32'd0);

    // Same-cycle bypass of a write.
    we_i       = 1'b1;
    wa_i       = 5'd5;
    wd_i       = 32'hDEAD_BEEF;
    rs1_addr_i = 5'd5;
    rs2_addr_i = 5'd6;
    #1;
    chk("bypass_rd1", rd1_o, 32'hDEAD_BEEF);
    chk("other_rd2",  rd2_o, 32'd6);
    tick();
    we_i = 1'b0;
    #1;
    chk("stored_r5", rd1_o, 32'hDEAD_BEEF);

    // Register 0 is hardwired: write and reserve both dropped.
    we_i        = 1'b1;
    wa_i        = 5'd0;
    wd_i        = 32'h1234;
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 5'd0;
    rs1_addr_i  = 5'd0;
    #1;
    chk("r0_rd1_pre",   rd1_o,             32'd0);
    chk("r0_busy1_pre", {31'd0, busy1_o},  32'd0);
    tick();
    we_i        = 1'b0;
    rsv_valid_i = 1'b0;
    #1;
    chk("r0_rd1_post",   rd1_o,            32'd0);
    chk("r0_busy1_post", {31'd0, busy1_o}, 32'd0);

    // Reserve then retire register 9.
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 5'd9;
    tick();
    rsv_valid_i = 1'b0;
    rs1_addr_i  = 5'd9;
    rs2_addr_i  = 5'd9;
    #1;
    chk("r9_busy2",  {31'd0, busy2_o},  32'd1);
    chk("r9_busy1",  {31'd0, busy1_o},  32'd1);
    chk("r9_hazard", {31'd0, hazard_o}, 32'd1);
    we_i = 1'b1;
    wa_i = 5'd9;
    wd_i = 32'h99;
    #1;
    chk("r9_busy2_bypass",  {31'd0, busy2_o},  32'd0);
    chk("r9_hazard_bypass", {31'd0, hazard_o}, 32'd0);
    chk("r9_rd2_bypass",    rd2_o,             32'h99);
    tick();
    we_i = 1'b0;
    #1;
    chk("r9_busy2_after", {31'd0, busy2_o}, 32'd0);
    chk("r9_rd2_after",   rd2_o,            32'h99);

    // Reserve and write same address in one cycle: reserve wins, data written.
    rsv_valid_i = 1'b1;
    rsv_addr_i  = 5'd3;
    we_i        = 1'b1;
    wa_i        = 5'd3;
    wd_i        = 32'h55;
    rs1_addr_i  = 5'd3;
    rs2_addr_i  = 5'd11;
    #1;
    chk("r3_busy1_pre", {31'd0, busy1_o}, 32'd0);
    chk("r3_rd1_pre",   rd1_o,            32'h55);
    tick();
    rsv_addr_i = 5'd11;
    we_i       = 1'b0;
    #1;
    chk("r3_rd1_post",   rd1_o,             32'h55);
    chk("r3_busy1_post", {31'd0, busy1_o},  32'd1);
    chk("r3_hazard",     {31'd0, hazard_o}, 32'd1);
    tick();
    rsv_valid_i = 1'b0;
    #1;
    chk("r11_busy2", {31'd0, busy2_o}, 32'd1);

    // Reset in RUN with busy bits set.
    rst_ni = 1'b0;
    tick();
    chk("rrun_ready",  {31'd0, ready_o},  32'd0);
    chk("rrun_busy1",  {31'd0, busy1_o},  32'd0);
    chk("rrun_hazard", {31'd0, hazard_o}, 32'd0);
    chk("rrun_rd1",    rd1_o,             32'd0);
    rst_ni = 1'b1;
    check_init_window("rrun_ready_win");
    #1;
    chk("rrun_busy1_after", {31'd0, busy1_o}, 32'd0);
    chk("rrun_busy2_after", {31'd0, busy2_o}, 32'd0);
    chk("rrun_r3_reinit",   rd1_o,            32'd3);

    // Reset mid-INIT at init_cnt = 10.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (10) tick();
    chk("mid_ready", {31'd0, ready_o}, 32'd0);
    rst_ni = 1'b0;
    tick();
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    rst_ni = 1'b1;
    check_init_window("mid_ready_win");
    rs1_addr_i = 5'd31;
    rs2_addr_i = 5'd20;
    #1;
    chk("mid_r31", rd1_o, 32'd31);
    chk("mid_r20", rd2_o, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
